// File: rtl/rom_fetch_unit.sv
// Fetch initiator for the case-ROM: PC, one-entry output register, valid/ready handoff.
// Optional FETCH_WRAP_HALT_EN: stop fetching after the last ROM address until a jump.
module rom_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  halted
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  running;
    logic                  load;

`ifdef FETCH_WRAP_HALT_EN
    typedef enum logic {RUN, HALT} state_e;
    state_e state_q, state_d;

    assign running = (state_q == RUN);
`else
    assign running = 1'b1;
`endif

    // The load edge doubles as the handshake edge when ready is high, so no bubble.
    assign load = running && enable && !jump && (!valid_q || instr_ready);

    always_comb begin
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (jump) begin
            pc_d    = jump_target;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 1'b1;
        end else if (valid_q && instr_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef FETCH_WRAP_HALT_EN
    always_comb begin
        state_d = state_q;
        if (jump) begin
            state_d = RUN;
        end else if (load && (pc_q == '1)) begin
            state_d = HALT;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            instr_pc_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
`ifdef FETCH_WRAP_HALT_EN
            state_q    <= RUN;
`endif
        end else begin
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
`ifdef FETCH_WRAP_HALT_EN
            state_q    <= state_d;
`endif
        end
    end

    assign rom_address = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
`ifdef FETCH_WRAP_HALT_EN
    assign halted      = (state_q == HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: directed test-plan scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_rom_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  rom_address;
    logic [15:0] rom_data;
    logic        jump;
    logic [7:0]  jump_target;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;

    logic [15:0] rom [256];

    int errors = 0;
    int checks = 0;

    // Model: next address to fetch, held word (address + data), stopped flag.
    int          m_pc;
    bit          m_valid;
    int          m_ipc;
    logic [15:0] m_instr;
    bit          m_halt;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_address];

    rom_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rom_address(rom_address),
        .rom_data(rom_data), .jump(jump), .jump_target(jump_target), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .halted(halted)
    );

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_ipc = 0; m_instr = '0; m_halt = 0;
    endtask

    // Advance one clock; model follows the word stream rules using current inputs.
    task automatic tick();
        int          n_pc    = m_pc;
        bit          n_valid = m_valid;
        int          n_ipc   = m_ipc;
        logic [15:0] n_instr = m_instr;
        bit          n_halt  = m_halt;
        if (jump) begin
            n_pc = int'(jump_target); n_valid = 0; n_halt = 0;
        end else if (!m_halt && enable && (!m_valid || instr_ready)) begin
            n_ipc = m_pc; n_instr = rom[m_pc]; n_valid = 1; n_pc = (m_pc + 1) % 256;
`ifdef FETCH_WRAP_HALT_EN
            if (m_pc == 255) n_halt = 1;
`endif
        end else if (m_valid && instr_ready) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_valid = n_valid; m_ipc = n_ipc; m_instr = n_instr; m_halt = n_halt;
    endtask

    task automatic do_jump(input int tgt);
        jump = 1; jump_target = 8'(tgt);
        tick();
        jump = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; jump = 0; jump_target = '0; instr_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rom_address !== 8'h00 || instr !== 16'h0 || instr_pc !== 8'h00 ||
            instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%h instr=%h pc=%h v=%b h=%b required 00 0000 00 0 0",
                     rom_address, instr, instr_pc, instr_valid, halted);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sweep();
        enable = 1; instr_ready = 1;
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(i) || instr !== rom[i]) begin
                errors++;
                $display("FAIL sweep[%0d]: v=%b pc=%h instr=%h required 1 %h %h",
                         i, instr_valid, instr_pc, instr, 8'(i), rom[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        enable = 1; instr_ready = 1;
        do_jump(0);
        repeat (6) tick();
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'h05 || instr !== rom[5] ||
                rom_address !== 8'h06) begin
                errors++;
                $display("FAIL backpressure[%0d]: v=%b pc=%h instr=%h addr=%h required 1 05 %h 06",
                         i, instr_valid, instr_pc, instr, rom_address, rom[5]);
            end
        end
        instr_ready = 1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h06 || instr !== rom[6]) begin
            errors++;
            $display("FAIL backpressure_release: v=%b pc=%h instr=%h required 1 06 %h",
                     instr_valid, instr_pc, instr, rom[6]);
        end
    endtask

    task automatic test_jump();
        enable = 1; instr_ready = 1;
        do_jump(8'h12);
        tick();
        do_jump(8'hA0);
        checks++;
        if (instr_valid !== 1'b0 || rom_address !== 8'hA0) begin
            errors++;
            $display("FAIL jump_bubble: v=%b addr=%h required 0 a0", instr_valid, rom_address);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(8'hA0 + i) || instr !== rom[8'hA0 + i]) begin
                errors++;
                $display("FAIL jump_target[%0d]: v=%b pc=%h instr=%h required 1 %h %h",
                         i, instr_valid, instr_pc, instr, 8'(8'hA0 + i), rom[8'hA0 + i]);
            end
        end
    endtask

    task automatic test_wrap();
        enable = 1; instr_ready = 1;
        do_jump(8'hFE);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(8'hFE + i)) begin
                errors++;
                $display("FAIL wrap_top[%0d]: v=%b pc=%h required 1 %h",
                         i, instr_valid, instr_pc, 8'(8'hFE + i));
            end
        end
`ifdef FETCH_WRAP_HALT_EN
        checks++;
        if (halted !== 1'b1 || rom_address !== 8'h00) begin
            errors++;
            $display("FAIL wrap_halt: halted=%b addr=%h required 1 00", halted, rom_address);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL wrap_halted[%0d]: v=%b halted=%b required 0 1", i, instr_valid, halted);
            end
        end
        do_jump(8'h10);
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h10 || halted !== 1'b0) begin
            errors++;
            $display("FAIL wrap_resume: v=%b pc=%h halted=%b required 1 10 0",
                     instr_valid, instr_pc, halted);
        end
`else
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(i) || instr !== rom[i] || halted !== 1'b0) begin
                errors++;
                $display("FAIL wrap_low[%0d]: v=%b pc=%h instr=%h halted=%b required 1 %h %h 0",
                         i, instr_valid, instr_pc, instr, halted, 8'(i), rom[i]);
            end
        end
`endif
    endtask

    task automatic test_enable();
        enable = 1; instr_ready = 1;
        do_jump(3);
        instr_ready = 0;
        tick();
        enable = 0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h03 || instr !== rom[3]) begin
            errors++;
            $display("FAIL enable_hold: v=%b pc=%h instr=%h required 1 03 %h",
                     instr_valid, instr_pc, instr, rom[3]);
        end
        instr_ready = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0 || rom_address !== 8'h04) begin
                errors++;
                $display("FAIL enable_idle[%0d]: v=%b addr=%h required 0 04", i, instr_valid, rom_address);
            end
        end
        enable = 1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h04 || instr !== rom[4]) begin
            errors++;
            $display("FAIL enable_resume: v=%b pc=%h instr=%h required 1 04 %h",
                     instr_valid, instr_pc, instr, rom[4]);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1; instr_ready = 1;
        do_jump(8'h3E);
        repeat (2) tick();
        checks++;
        if (rom_address !== 8'h40 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: addr=%h v=%b required 40 1", rom_address, instr_valid);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (rom_address !== 8'h00 || instr !== 16'h0 || instr_pc !== 8'h00 ||
            instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: addr=%h instr=%h pc=%h v=%b h=%b required 00 0000 00 0 0",
                     rom_address, instr, instr_pc, instr_valid, halted);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== rom[0]) begin
            errors++;
            $display("FAIL reset_mid_first: v=%b pc=%h instr=%h required 1 00 %h",
                     instr_valid, instr_pc, instr, rom[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            enable      = ($urandom_range(0, 9) < 8);
            instr_ready = ($urandom_range(0, 9) < 7);
            jump        = ($urandom_range(0, 19) == 0);
            jump_target = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if (instr_valid !== m_valid || instr_pc !== 8'(m_ipc) || instr !== m_instr ||
                rom_address !== 8'(m_pc) || halted !== m_halt) begin
                errors++;
                $display("FAIL random[%0d]: v=%b pc=%h instr=%h addr=%h h=%b required %b %h %h %h %b",
                         i, instr_valid, instr_pc, instr, rom_address, halted,
                         m_valid, 8'(m_ipc), m_instr, 8'(m_pc), m_halt);
            end
        end
        jump = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        test_reset();
        test_sweep();
        test_backpressure();
        test_jump();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
